// File: rtl/frame_capture_ctrl_if.sv
// Frame capture control bus.
// Groups the capture request/sync/pixel inputs and the frame-buffer write and
// status outputs of frame_capture_ctrl.
//   start       one-cycle request to arm a capture
//   continuous  level; re-arm automatically after each frame
//   vsync       camera frame sync, rising edge marks a frame boundary
//   pix_valid   downsampler sample-ready strobe
//   pix_data    downsampled RGB332 pixel
//   pix_x/pix_y pixel column/row
//   wr_en       frame-buffer write strobe
//   wr_addr     frame-buffer write address
//   wr_data     frame-buffer write data
//   busy        capture armed or in progress
//   frame_done  one-cycle pulse on frame completion
//   frame_cnt   completed-frame count, wraps at 256
//   err_ovf     sticky out-of-frame pixel flag
interface frame_capture_ctrl_if;
    logic        start;
    logic        continuous;
    logic        vsync;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic [14:0] pix_x;
    logic [14:0] pix_y;
    logic        wr_en;
    logic [14:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
    logic        frame_done;
    logic [7:0]  frame_cnt;
    logic        err_ovf;

    modport master (
        output start, continuous, vsync, pix_valid, pix_data, pix_x, pix_y,
        input  wr_en, wr_addr, wr_data, busy, frame_done, frame_cnt, err_ovf
    );

    modport slave (
        input  start, continuous, vsync, pix_valid, pix_data, pix_x, pix_y,
        output wr_en, wr_addr, wr_data, busy, frame_done, frame_cnt, err_ovf
    );
endinterface

// File: rtl/frame_capture_ctrl.sv
// Frame capture controller.
// Arms on a start request, waits for a vsync rising edge, then writes every
// in-frame pixel to the frame buffer at address y*WIDTH+x until the next vsync
// rising edge. Out-of-frame pixels are dropped and flagged in err_ovf.
// Ports:
//   clk  system clock, rising edge
//   res  asynchronous active-high reset
//   bus  frame_capture_ctrl_if.slave (pixel input, frame-buffer write, status)
//
// state   | meaning
// --------+--------------------------------------------------------
// IDLE    | waiting for start
// ARM     | waiting for the vsync edge that opens a frame
// CAPTURE | writing pixels until the vsync edge that closes the frame
// DONE    | one cycle: frame_done pulse, frame counter increment
module frame_capture_ctrl #(
    parameter int WIDTH  = 176,
    parameter int HEIGHT = 144
) (
    input  logic                clk,
    input  logic                res,
    frame_capture_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_t;

    localparam logic [15:0] W_LIM = 16'(WIDTH);
    localparam logic [15:0] H_LIM = 16'(HEIGHT);
    localparam logic [29:0] W_MUL = 30'(WIDTH);

    state_t      state;
    state_t      state_nxt;
    logic        vsync_q;
    logic        vsync_rise;
    logic        in_range;
    logic [14:0] addr;

    assign vsync_rise = bus.vsync & ~vsync_q;
    assign in_range   = ({1'b0, bus.pix_x} < W_LIM) && ({1'b0, bus.pix_y} < H_LIM);
    // Full 30-bit product; any in-frame address fits 15 bits when the frame
    // holds at most 32768 pixels.
    assign addr       = 15'({15'd0, bus.pix_y} * W_MUL + {15'd0, bus.pix_x});

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state   <= IDLE;
            vsync_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            vsync_q <= bus.vsync;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = ARM;
            ARM:     if (vsync_rise) state_nxt = CAPTURE;
            CAPTURE: if (vsync_rise) state_nxt = DONE;
            // In continuous mode the closing vsync edge also opens the next frame.
            DONE:    state_nxt = bus.continuous ? CAPTURE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.frame_done = (state == DONE);
        // Keep busy high through DONE when re-arming so it never drops
        // between back-to-back continuous frames.
        bus.busy = (state == ARM) || (state == CAPTURE) ||
                   ((state == DONE) && bus.continuous);
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            bus.wr_en     <= 1'b0;
            bus.wr_addr   <= 15'd0;
            bus.wr_data   <= 8'd0;
            bus.frame_cnt <= 8'd0;
            bus.err_ovf   <= 1'b0;
        end else begin
            bus.wr_en <= 1'b0;
            if ((state == CAPTURE) && bus.pix_valid) begin
                if (in_range) begin
                    bus.wr_en   <= 1'b1;
                    bus.wr_addr <= addr;
                    bus.wr_data <= bus.pix_data;
                end else begin
                    bus.err_ovf <= 1'b1;
                end
            end
            if ((state == IDLE) && bus.start) begin
                bus.err_ovf <= 1'b0;
            end
            if (state == DONE) begin
                bus.frame_cnt <= bus.frame_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_frame_capture_ctrl.sv
module tb_frame_capture_ctrl;
    localparam int W = 176;
    localparam int H = 144;

    logic clk = 1'b0;
    logic res = 1'b1;
    always #5 clk = ~clk;

    frame_capture_ctrl_if b ();

    frame_capture_ctrl #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk (clk),
        .res (res),
        .bus (b)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_writes = 0;
    int n_done = 0;
    bit watch_busy = 0;

    // Reference model: what the bench believes about the capture session.
    bit m_armed = 0;
    bit m_cap = 0;
    bit m_ovf = 0;
    int m_cnt = 0;
    logic [22:0] wq[$];  // expected writes {addr, data}, due on the next edge

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic exp_wr;
        logic [22:0] e;
        @(posedge clk);
        #1;
        exp_wr = (wq.size() != 0);
        check("wr_en", 32'(b.wr_en), 32'(exp_wr));
        if (exp_wr) begin
            e = wq.pop_front();
            if (b.wr_en === 1'b1) begin
                check("wr_addr", 32'(b.wr_addr), 32'(e[22:8]));
                check("wr_data", 32'(b.wr_data), 32'(e[7:0]));
                n_writes++;
            end
        end
        if (b.frame_done === 1'b1) n_done++;
        if (watch_busy) check("busy_hold", 32'(b.busy), 1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_wr_en"},      32'(b.wr_en), 0);
        check({tag, "_wr_addr"},    32'(b.wr_addr), 0);
        check({tag, "_wr_data"},    32'(b.wr_data), 0);
        check({tag, "_busy"},       32'(b.busy), 0);
        check({tag, "_frame_done"}, 32'(b.frame_done), 0);
        check({tag, "_frame_cnt"},  32'(b.frame_cnt), 0);
        check({tag, "_err_ovf"},    32'(b.err_ovf), 0);
    endtask

    task automatic model_reset();
        m_armed = 0; m_cap = 0; m_ovf = 0; m_cnt = 0;
        wq.delete();
    endtask

    task automatic apply_reset();
        res = 1'b1;
        model_reset();
        tick();
        tick();
        check_zero("reset");
        res = 1'b0;
    endtask

    task automatic pixel(input int x, input int y, input logic [7:0] d);
        b.pix_valid = 1'b1;
        b.pix_x = 15'(x);
        b.pix_y = 15'(y);
        b.pix_data = d;
        if (m_cap) begin
            if (x < W && y < H) wq.push_back({15'(y * W + x), d});
            else m_ovf = 1;
        end
        tick();
        check("err_ovf", 32'(b.err_ovf), 32'(m_ovf));
    endtask

    task automatic idle_cycle();
        b.pix_valid = 1'b0;
        tick();
    endtask

    task automatic start_req();
        b.start = 1'b1;
        if (!m_cap && !m_armed) begin
            m_armed = 1;
            m_ovf = 0;
        end
        tick();
        b.start = 1'b0;
        check("busy_start", 32'(b.busy), 32'(m_armed | m_cap));
        check("err_ovf_start", 32'(b.err_ovf), 32'(m_ovf));
    endtask

    // A pixel set up by the caller beforehand shares the vsync rising cycle.
    task automatic vsync_pulse();
        bit ending;
        ending = m_cap;
        b.vsync = 1'b1;
        if (m_armed) begin
            m_armed = 0;
            m_cap = 1;
        end else if (m_cap) begin
            m_cnt = (m_cnt + 1) % 256;
            m_cap = b.continuous;
        end
        tick();
        b.vsync = 1'b0;
        b.pix_valid = 1'b0;
        check("frame_done", 32'(b.frame_done), 32'(ending));
        tick();
        check("frame_done_len", 32'(b.frame_done), 0);
        check("frame_cnt", 32'(b.frame_cnt), 32'(m_cnt));
        check("busy", 32'(b.busy), 32'(m_armed | m_cap));
        check("err_ovf_hold", 32'(b.err_ovf), 32'(m_ovf));
    endtask

    task automatic random_pixels(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) idle_cycle();
            pixel(int'($urandom_range(0, W + 9)), int'($urandom_range(0, H + 6)),
                  8'($urandom_range(0, 255)));
        end
        idle_cycle();
    endtask

    initial begin
        int w0;
        int d0;
        b.start = 0; b.continuous = 0; b.vsync = 0; b.pix_valid = 0;
        b.pix_data = 0; b.pix_x = 0; b.pix_y = 0;
        #1;
        check_zero("reset_async");
        apply_reset();

        // Nothing happens in IDLE.
        pixel(3, 3, 8'h11);
        idle_cycle();
        vsync_pulse();

        // Arm; pixels and repeated start in ARM are ignored.
        start_req();
        pixel(4, 4, 8'h22);
        idle_cycle();
        start_req();
        vsync_pulse();

        pixel(5, 2, 8'hA5);
        check("addr_wr_en", 32'(b.wr_en), 1);
        check("addr_357", 32'(b.wr_addr), 357);
        check("addr_data", 32'(b.wr_data), 32'h A5);
        idle_cycle();

        pixel(176, 0, 8'h33);
        check("ovf_no_write", 32'(b.wr_en), 0);
        check("ovf_flag", 32'(b.err_ovf), 1);
        pixel(0, 144, 8'h34);
        pixel(175, 143, 8'h35);
        idle_cycle();

        random_pixels(300);
        start_req();

        // Pixel written in the same cycle as the closing vsync edge.
        b.pix_valid = 1'b1; b.pix_x = 15'd10; b.pix_y = 15'd10; b.pix_data = 8'h5C;
        wq.push_back({15'(10 * W + 10), 8'h5C});
        vsync_pulse();
        check("ovf_sticky_idle", 32'(b.err_ovf), 1);

        // Full frame in raster order, back to back.
        start_req();
        vsync_pulse();
        w0 = n_writes;
        d0 = n_done;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                pixel(x, y, 8'($urandom_range(0, 255)));
        idle_cycle();
        vsync_pulse();
        check("frame_writes", 32'(n_writes - w0), 25344);
        check("frame_dones", 32'(n_done - d0), 1);
        check("frame_cnt_2", 32'(b.frame_cnt), 2);

        // Asynchronous reset in the middle of a capture.
        start_req();
        vsync_pulse();
        pixel(7, 1, 8'h77);
        idle_cycle();
        b.pix_valid = 1'b1; b.pix_x = 15'd8; b.pix_y = 15'd1; b.pix_data = 8'h78;
        #2;
        res = 1'b1;
        model_reset();
        #1;
        check_zero("mid_reset");
        tick();
        tick();
        res = 1'b0;
        pixel(9, 1, 8'h79);
        pixel(10, 1, 8'h7A);
        vsync_pulse();
        pixel(11, 1, 8'h7B);
        idle_cycle();
        check("post_reset_idle", 32'(b.busy), 0);
        start_req();
        vsync_pulse();
        pixel(12, 1, 8'h7C);
        idle_cycle();

        // Continuous mode: busy never drops, counter wraps.
        apply_reset();
        b.continuous = 1'b1;
        start_req();
        watch_busy = 1;
        d0 = n_done;
        vsync_pulse();
        random_pixels(20);
        vsync_pulse();
        random_pixels(20);
        vsync_pulse();
        check("cont_dones", 32'(n_done - d0), 2);
        check("cont_cnt", 32'(b.frame_cnt), 2);
        while (m_cnt != 255) vsync_pulse();
        check("cnt_255", 32'(b.frame_cnt), 255);
        vsync_pulse();
        check("cnt_wrap", 32'(b.frame_cnt), 0);
        watch_busy = 0;
        b.continuous = 1'b0;
        vsync_pulse();
        check("cont_stop_busy", 32'(b.busy), 0);
        check("cont_stop_cnt", 32'(b.frame_cnt), 1);
        idle_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/frame_capture_ctrl.md
FRAME_CAPTURE_CTRL -- requirements
Module: frame_capture_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 176, frame width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 144, frame height in lines.
REQ-003 SHALL have port CLK  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port RES  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port START  input  1  one-cycle request to arm a capture.
REQ-006 SHALL have port CONTINUOUS  input  1  level; when high, re-arm automatically after each frame.
REQ-007 SHALL have port VSYNC  input  1  camera frame sync; rising edge marks frame boundary.
REQ-008 SHALL have port PIX_VALID  input  1  downsampler sample-ready strobe.
REQ-009 SHALL have port PIX_DATA  input  8  downsampled pixel (RGB332).
REQ-010 SHALL have port PIX_X  input  15  pixel column from downsampler.
REQ-011 SHALL have port PIX_Y  input  15  pixel row from downsampler.
REQ-012 SHALL have port WR_EN  output  1  frame-buffer write strobe.
REQ-013 SHALL have port WR_ADDR  output  15  frame-buffer write address.
REQ-014 SHALL have port WR_DATA  output  8  frame-buffer write data.
REQ-015 SHALL have port BUSY  output  1  high in ARM or CAPTURE.
REQ-016 SHALL have port FRAME_DONE  output  1  one-cycle pulse on frame completion.
REQ-017 SHALL have port FRAME_CNT  output  8  completed-frame count.
REQ-018 SHALL have port ERR_OVF  output  1  sticky flag: a pixel fell outside WIDTH x HEIGHT.

Function
REQ-019 SHALL register VSYNC once and detect its rising edge as VSYNC high and previous sample low.
REQ-020 SHALL implement states IDLE, ARM, CAPTURE, DONE.
REQ-021 IDLE: on START go to ARM and clear ERR_OVF; otherwise stay.
REQ-022 ARM: on VSYNC rising edge go to CAPTURE; pixels in ARM SHALL be ignored.
REQ-023 CAPTURE: on each PIX_VALID with PIX_X<WIDTH and PIX_Y<HEIGHT, SHALL assert WR_EN the next cycle with WR_ADDR=PIX_Y*WIDTH+PIX_X and WR_DATA=PIX_DATA (1-cycle latency).
REQ-024 CAPTURE: PIX_VALID with PIX_X>=WIDTH or PIX_Y>=HEIGHT SHALL produce no write and SHALL set ERR_OVF.
REQ-025 CAPTURE: on VSYNC rising edge go to DONE; a PIX_VALID in the same cycle SHALL still be written.
REQ-026 DONE (one cycle): SHALL pulse FRAME_DONE and increment FRAME_CNT modulo 256 (255 wraps to 0).
REQ-027 DONE: if CONTINUOUS high, go directly to CAPTURE (the ending VSYNC edge also starts the next frame); else go to IDLE.
REQ-028 START while not in IDLE SHALL be ignored.
REQ-029 WR_EN SHALL be low whenever no write is due; WR_ADDR/WR_DATA hold last values.
REQ-030 Address arithmetic SHALL be computed at >=15 bits with no truncation for WIDTH*HEIGHT<=32768.

Reset
REQ-031 RES high SHALL asynchronously force state IDLE, WR_EN=0, WR_ADDR=0, WR_DATA=0, BUSY=0, FRAME_DONE=0, FRAME_CNT=0, ERR_OVF=0, VSYNC history=0.
REQ-032 RES asserted mid-capture SHALL abort the frame with no further writes; after release, capture SHALL require a new START.

Verification
REQ-033 Single frame: START, VSYNC rise, pixels (x=0..175,y=0..143), VSYNC rise -> 25344 writes, addr 0..25343 in order, one FRAME_DONE, FRAME_CNT=1, back to IDLE.
REQ-034 Address check: PIX_VALID with x=5,y=2,data=0xA5 in CAPTURE -> next cycle WR_EN=1, WR_ADDR=357, WR_DATA=0xA5.
REQ-035 Overflow: PIX_VALID with x=176,y=0 -> no WR_EN, ERR_OVF=1 and stays 1 until next START from IDLE.
REQ-036 Continuous: CONTINUOUS=1, START, 3 VSYNC rises -> FRAME_DONE twice, BUSY never drops, FRAME_CNT=2; also preload 255 frames -> wraps to 0.
REQ-037 Simultaneous: PIX_VALID and VSYNC rise same cycle in CAPTURE -> pixel written, FRAME_DONE next cycle.
REQ-038 Reset mid-capture: RES pulse during CAPTURE -> all outputs 0 immediately, no writes after, PIX_VALID ignored until START plus VSYNC rise.
